// File: rtl/axi_lite_pkg.sv
// Shared types and constants for the AXI4-Lite master bridge and its interface.
package axi_lite_pkg;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_WR_REQ,
        ST_WR_RESP,
        ST_RSP
    } state_e;

    // Anything other than OKAY is reported to the core as an error.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_if.sv
// AXI4-Lite channel bundle (ar/r/aw/w/b) with master and slave views.
interface axi_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;

    logic              rvalid;
    logic              rready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;

    logic              awvalid;
    logic              awready;
    logic [ADDR_W-1:0] awaddr;

    logic                wvalid;
    logic                wready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;

    logic       bvalid;
    logic       bready;
    logic [1:0] bresp;

    modport master (
        output arvalid, araddr, rready, awvalid, awaddr, wvalid, wdata, wstrb, bready,
        input  arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp
    );

    modport slave (
        input  arvalid, araddr, rready, awvalid, awaddr, wvalid, wdata, wstrb, bready,
        output arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp
    );
endinterface

// File: rtl/axi_lite_master_bridge.sv
// AXI4-Lite master: turns one core load/store request into one AXI read or
// write transaction and holds the result on the response port until taken.
// Optional watchdog: define AXI_MASTER_TIMEOUT_EN to abort stuck transactions
// after TIMEOUT_CYCLES with an error response.
module axi_lite_master_bridge
    import axi_lite_pkg::*;
#(
    parameter int ADDR_W         = AXI_ADDR_W,
    parameter int DATA_W         = AXI_DATA_W,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_wen,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_wstrb,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    axi_if.master               axi
);

    // Configuration sanity checks at elaboration.
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end
    if ((DATA_W % 8) != 0) begin : g_bad_data_w
        $error("DATA_W must be a multiple of 8");
    end

    state_e              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W/8-1:0] wstrb_q;

    logic arvalid_q, rready_q;
    logic awvalid_q, wvalid_q, bready_q;
    logic aw_done_q, w_done_q;

    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rsp_err_q;

    logic aw_hs, w_hs;
    logic aw_done_d, w_done_d;

`ifdef AXI_MASTER_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    // Value seen in the cycle whose increment reaches TIMEOUT_CYCLES.
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             busy;
    logic             tmo;
`endif

    // Write-channel handshakes and the completion flags including this cycle.
    always_comb begin
        aw_hs     = awvalid_q & axi.awready;
        w_hs      = wvalid_q & axi.wready;
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
    end

`ifdef AXI_MASTER_TIMEOUT_EN
    // Watchdog fires while a transaction is outstanding on the bus.
    always_comb begin
        busy = (state_q == ST_RD_ADDR) || (state_q == ST_RD_DATA) ||
               (state_q == ST_WR_REQ)  || (state_q == ST_WR_RESP);
        tmo  = busy && (cnt_q == TMO_LAST);
    end
`endif

    // Main FSM with registered AXI and response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
`ifdef AXI_MASTER_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // req_ready is high in IDLE, so req_valid alone accepts.
                    if (req_valid) begin
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        wstrb_q   <= req_wstrb;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        if (req_wen) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= ST_WR_REQ;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= ST_RD_ADDR;
                        end
                    end
                end
                ST_RD_ADDR: begin
                    if (axi.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (axi.rvalid) begin
                        rready_q    <= 1'b0;
                        rsp_rdata_q <= axi.rdata;
                        rsp_err_q   <= resp_is_err(axi.rresp);
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_RSP;
                    end
                end
                ST_WR_REQ: begin
                    // aw and w complete independently; each valid drops after its own beat.
                    if (aw_hs) awvalid_q <= 1'b0;
                    if (w_hs)  wvalid_q  <= 1'b0;
                    aw_done_q <= aw_done_d;
                    w_done_q  <= w_done_d;
                    if (aw_done_d && w_done_d) begin
                        bready_q <= 1'b1;
                        state_q  <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (axi.bvalid) begin
                        bready_q    <= 1'b0;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= resp_is_err(axi.bresp);
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

`ifdef AXI_MASTER_TIMEOUT_EN
            // Debug watchdog: abandons the bus mid-handshake and reports an error.
            if (state_q == ST_IDLE) begin
                cnt_q <= '0;
            end else if (busy) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (tmo) begin
                arvalid_q   <= 1'b0;
                rready_q    <= 1'b0;
                awvalid_q   <= 1'b0;
                wvalid_q    <= 1'b0;
                bready_q    <= 1'b0;
                rsp_rdata_q <= '0;
                rsp_err_q   <= 1'b1;
                rsp_valid_q <= 1'b1;
                state_q     <= ST_RSP;
            end
`endif
        end
    end

    assign req_ready = (state_q == ST_IDLE) && !rst;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    assign axi.arvalid = arvalid_q;
    assign axi.araddr  = addr_q;
    assign axi.rready  = rready_q;
    assign axi.awvalid = awvalid_q;
    assign axi.awaddr  = addr_q;
    assign axi.wvalid  = wvalid_q;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wstrb_q;
    assign axi.bready  = bready_q;

endmodule

// File: tb/tb_axi_lite_master_bridge.sv
// Scoreboard bench for axi_lite_master_bridge: directed transactions push the
// expected response; a negedge monitor compares every presented response.
module tb_axi_lite_master_bridge;
    import axi_lite_pkg::*;

`ifdef AXI_MASTER_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 255;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_wen;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    axi_if #(.ADDR_W(32), .DATA_W(32)) axi ();

    axi_lite_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .axi(axi)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int total = 0;
    int bad   = 0;
    int ar_cnt = 0, aw_cnt = 0, w_cnt = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Monitor: count AXI beats and check every presented response against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (axi.arvalid && axi.arready) ar_cnt++;
            if (axi.awvalid && axi.awready) aw_cnt++;
            if (axi.wvalid && axi.wready)   w_cnt++;
            if (rsp_valid) begin
                if (sb_q.size() == 0) begin
                    chk("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    chk("rsp_rdata", rsp_rdata, sb_q[0].rdata);
                    chk("rsp_err", {31'd0, rsp_err}, {31'd0, sb_q[0].err});
                    if (rsp_ready) void'(sb_q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wen, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] strb);
        int n = 0;
        req_valid = 1'b1; req_wen = wen; req_addr = addr;
        req_wdata = data; req_wstrb = strb;
        while (!req_ready && n < 50) begin tick(); n++; end
        if (!req_ready) chk("req_ready_timeout", 32'd0, 32'd1);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic finish_rsp(input int hold);
        int n = 0;
        while (!rsp_valid && n < 50) begin tick(); n++; end
        chk("rsp_valid_seen", {31'd0, rsp_valid}, 32'd1);
        for (int i = 0; i < hold; i++) begin
            chk("req_ready_in_rsp", {31'd0, req_ready}, 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("req_ready_after_rsp", {31'd0, req_ready}, 32'd1);
        chk("rsp_valid_dropped", {31'd0, rsp_valid}, 32'd0);
    endtask

    task automatic do_read(input logic [31:0] addr, input int ar_dly, input int r_dly,
                           input logic [31:0] rdata, input logic [1:0] rresp, input int hold);
        int ar0 = ar_cnt;
        sb_q.push_back(exp_t'{rdata, (rresp != RESP_OKAY)});
        issue(1'b0, addr, 32'd0, 4'd0);
        chk("arvalid_lat", {31'd0, axi.arvalid}, 32'd1);
        chk("araddr", axi.araddr, addr);
        for (int i = 0; i < ar_dly; i++) begin
            chk("arvalid_hold", {31'd0, axi.arvalid}, 32'd1);
            chk("araddr_hold", axi.araddr, addr);
            tick();
        end
        axi.arready = 1'b1;
        tick();
        axi.arready = 1'b0;
        chk("arvalid_drop", {31'd0, axi.arvalid}, 32'd0);
        chk("rready_up", {31'd0, axi.rready}, 32'd1);
        for (int i = 0; i < r_dly; i++) tick();
        axi.rvalid = 1'b1; axi.rdata = rdata; axi.rresp = rresp;
        tick();
        axi.rvalid = 1'b0; axi.rdata = 32'hx; axi.rresp = 2'b00;
        chk("rd_rsp_lat", {31'd0, rsp_valid}, 32'd1);
        chk("rready_drop", {31'd0, axi.rready}, 32'd0);
        finish_rsp(hold);
        chk("ar_beats", ar_cnt - ar0, 32'd1);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_dly,
                            input logic [1:0] bresp, input int hold);
        int aw0 = aw_cnt;
        int w0  = w_cnt;
        int last = (aw_dly > w_dly) ? aw_dly : w_dly;
        sb_q.push_back(exp_t'{32'd0, (bresp != RESP_OKAY)});
        issue(1'b1, addr, data, strb);
        for (int c = 0; c <= last; c++) begin
            axi.awready = (c == aw_dly);
            axi.wready  = (c == w_dly);
            chk("awvalid", {31'd0, axi.awvalid}, (c <= aw_dly) ? 32'd1 : 32'd0);
            chk("wvalid", {31'd0, axi.wvalid}, (c <= w_dly) ? 32'd1 : 32'd0);
            chk("bready_early", {31'd0, axi.bready}, 32'd0);
            if (c <= aw_dly) chk("awaddr", axi.awaddr, addr);
            if (c <= w_dly) begin
                chk("wdata", axi.wdata, data);
                chk("wstrb", {28'd0, axi.wstrb}, {28'd0, strb});
            end
            tick();
        end
        axi.awready = 1'b0; axi.wready = 1'b0;
        chk("awvalid_off", {31'd0, axi.awvalid}, 32'd0);
        chk("wvalid_off", {31'd0, axi.wvalid}, 32'd0);
        chk("wr_resp_reached", {31'd0, axi.bready}, 32'd1);
        for (int i = 0; i < b_dly; i++) tick();
        axi.bvalid = 1'b1; axi.bresp = bresp;
        tick();
        axi.bvalid = 1'b0; axi.bresp = 2'b00;
        chk("wr_rsp_lat", {31'd0, rsp_valid}, 32'd1);
        chk("bready_drop", {31'd0, axi.bready}, 32'd0);
        finish_rsp(hold);
        chk("aw_beats", aw_cnt - aw0, 32'd1);
        chk("w_beats", w_cnt - w0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_addr = '0;
        req_wdata = '0; req_wstrb = '0; rsp_ready = 1'b0;
        axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = 2'b00;
        axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
        tick(); tick();

        // Reset state
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_arvalid", {31'd0, axi.arvalid}, 32'd0);
        chk("rst_awvalid", {31'd0, axi.awvalid}, 32'd0);
        chk("rst_wvalid", {31'd0, axi.wvalid}, 32'd0);
        chk("rst_rready", {31'd0, axi.rready}, 32'd0);
        chk("rst_bready", {31'd0, axi.bready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        rst = 1'b0;
        #1;
        chk("idle_req_ready", {31'd0, req_ready}, 32'd1);

        do_read(32'h8000_0010, 0, 1, 32'hDEAD_BEEF, RESP_OKAY, 0);
        do_write(32'h1000_03F8, 32'h0000_0041, 4'b0001, 3, 0, 0, RESP_OKAY, 0);
        do_write(32'h1000_0400, 32'hA5A5_5A5A, 4'b1111, 0, 2, 1, RESP_OKAY, 0);
        do_write(32'h1000_0404, 32'h0102_0304, 4'b0110, 0, 0, 0, RESP_OKAY, 0);
        do_read(32'h2000_0000, 2, 0, 32'h1234_5678, RESP_EXOKAY, 5);
        do_read(32'h2000_0004, 0, 0, 32'hCAFE_F00D, RESP_SLVERR, 0);
        do_write(32'h3000_0000, 32'hFFFF_FFFF, 4'b1100, 1, 1, 2, RESP_DECERR, 2);

        // Stray rvalid/bvalid in IDLE must be ignored
        axi.rvalid = 1'b1; axi.bvalid = 1'b1;
        chk("stray_rready", {31'd0, axi.rready}, 32'd0);
        chk("stray_bready", {31'd0, axi.bready}, 32'd0);
        tick();
        axi.rvalid = 1'b0; axi.bvalid = 1'b0;
        chk("stray_idle", {31'd0, req_ready}, 32'd1);
        chk("stray_no_rsp", {31'd0, rsp_valid}, 32'd0);

        // Reset while waiting in WR_RESP abandons the write
        issue(1'b1, 32'h4000_0000, 32'h5555_AAAA, 4'hF);
        axi.awready = 1'b1; axi.wready = 1'b1;
        tick();
        axi.awready = 1'b0; axi.wready = 1'b0;
        chk("pre_rst_bready", {31'd0, axi.bready}, 32'd1);
        rst = 1'b1;
        tick();
        chk("mid_rst_arvalid", {31'd0, axi.arvalid}, 32'd0);
        chk("mid_rst_awvalid", {31'd0, axi.awvalid}, 32'd0);
        chk("mid_rst_wvalid", {31'd0, axi.wvalid}, 32'd0);
        chk("mid_rst_rready", {31'd0, axi.rready}, 32'd0);
        chk("mid_rst_bready", {31'd0, axi.bready}, 32'd0);
        chk("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("mid_rst_req_ready", {31'd0, req_ready}, 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_req_ready", {31'd0, req_ready}, 32'd1);

`ifdef AXI_MASTER_TIMEOUT_EN
        // Watchdog: arready never comes
        begin
            int n = 0;
            sb_q.push_back(exp_t'{32'd0, 1'b1});
            issue(1'b0, 32'h5000_0000, 32'd0, 4'd0);
            while (!rsp_valid && n < 30) begin tick(); n++; end
            chk("tmo_cycles", n, 32'd8);
            chk("tmo_arvalid", {31'd0, axi.arvalid}, 32'd0);
            finish_rsp(0);
        end
`endif

        tick(); tick();
        chk("sb_drained", sb_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
